// File: rtl/tile_setup_engine.sv
// Tile setup engine: per-triangle edge values and z plane at a tile origin.
// One triangle in flight; a single serial divider is reused for dz/dx and dz/dy.
//
// state | meaning
// IDLE  | ready for a triangle, rdy_in high
// SETUP | edges, determinant and plane normals from the captured vertices
// DIV_X | serial divide nx*2^F/det, one quotient bit per cycle
// DIV_Y | serial divide ny*2^F/det, one quotient bit per cycle
// ZCALC | z at the tile origin, load all output registers
// OUT   | hold outputs until rdy_out
module tile_setup_engine #(
   parameter int FX_INT_BITS  = 12,
   parameter int FX_FRAC_BITS = 4,
   parameter int TILE_SHIFT   = 5,
   parameter int TILE_X_BITS  = 5,
   parameter int TILE_Y_BITS  = 5,
   parameter int CULL_EN      = 1,
   localparam int W  = FX_INT_BITS + FX_FRAC_BITS,
   localparam int W2 = 2 * W,
   localparam int D  = W2 + FX_FRAC_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vld_in,
   output logic                   rdy_in,
   input  logic [3*W-1:0]         v0,
   input  logic [3*W-1:0]         v1,
   input  logic [3*W-1:0]         v2,
   input  logic [TILE_X_BITS-1:0] tile_x,
   input  logic [TILE_Y_BITS-1:0] tile_y,
   input  logic [7:0]             tag_in,
   output logic [7:0]             tag_out,
   output logic                   vld_out,
   input  logic                   rdy_out,
   output logic [W-1:0]           out_origin_x,
   output logic [W-1:0]           out_origin_y,
   output logic [W2-1:0]          out_edge_0,
   output logic [W2-1:0]          out_edge_1,
   output logic [W2-1:0]          out_edge_2,
   output logic [W-1:0]           out_dzdx,
   output logic [W-1:0]           out_dzdy,
   output logic [W2-1:0]          out_z,
   output logic [3*W-1:0]         out_delta_0,
   output logic [3*W-1:0]         out_delta_1,
   output logic [3*W-1:0]         out_delta_2,
   output logic [15:0]            drop_count
);

   localparam int CW = $clog2(D);

   typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DIV_Y, ZCALC, OUT} state_t;

   state_t                 state_q;
   logic                   rdy_in_q, vld_out_q, dneg_q, qneg_q;
   logic [3*W-1:0]         v0_q, v1_q, v2_q;
   logic [TILE_X_BITS-1:0] tx_q;
   logic [TILE_Y_BITS-1:0] ty_q;
   logic [7:0]             tag_q, tag_out_q;
   logic [W2-1:0]          e0_q, e1_q, e2_q, ny_q, dmag_q, rem_q;
   logic [D-1:0]           quo_q;
   logic [CW-1:0]          cnt_q;
   logic [W-1:0]           dzdx_q, dzdy_q;
   logic [15:0]            drop_cnt_q;
   logic [W-1:0]           ox_out_q, oy_out_q, dzdx_out_q, dzdy_out_q;
   logic [W2-1:0]          edge0_q, edge1_q, edge2_q, z_out_q;
   logic [3*W-1:0]         dl0_q, dl1_q, dl2_q;

   // full-width signed product of two W-bit operands
   function automatic logic [W2-1:0] smul(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      logic signed [W2-1:0] aa, bb;
      aa = a;
      bb = b;
      return aa * bb;
   endfunction

   // magnitude of the numerator, pre-scaled by 2^FX_FRAC_BITS
   function automatic logic [D-1:0] dividend(input logic [W2-1:0] n);
      logic [W2-1:0] m;
      m = n[W2-1] ? -n : n;
      return {m, {FX_FRAC_BITS{1'b0}}};
   endfunction

   // apply the quotient sign and clamp to the W-bit signed range
   function automatic logic [W-1:0] sat_q(input logic [D-1:0] q, input logic neg);
      logic [D-1:0] qn;
      qn = -q;
      if (!neg)
         return (q > D'({(W-1){1'b1}})) ? {1'b0, {(W-1){1'b1}}} : q[W-1:0];
      else
         return (q > D'({1'b1, {(W-1){1'b0}}})) ? {1'b1, {(W-1){1'b0}}} : qn[W-1:0];
   endfunction

   logic [W-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2, ox, oy;
   logic [W-1:0] d0x, d0y, d0z, d1x, d1y, d1z, d2x, d2y, d2z;
   logic [W-1:0] rx0, ry0, rx1, ry1, rx2, ry2;
   logic [W2-1:0] det, dmag, nx, ny, e0, e1, e2, zc;
   logic          drop, ge;
   logic [W2:0]   rem_sh, rem_sub;
   logic [W2-1:0] rem_d;
   logic [D-1:0]  quo_d;
   logic [W-1:0]  dz_res;

   assign {x0, y0, z0} = v0_q;
   assign {x1, y1, z1} = v1_q;
   assign {x2, y2, z2} = v2_q;
   assign ox = W'(tx_q) << (TILE_SHIFT + FX_FRAC_BITS);
   assign oy = W'(ty_q) << (TILE_SHIFT + FX_FRAC_BITS);

   assign d0x = x1 - x0;  assign d0y = y1 - y0;  assign d0z = z1 - z0;
   assign d1x = x2 - x1;  assign d1y = y2 - y1;  assign d1z = z2 - z1;
   assign d2x = x0 - x2;  assign d2y = y0 - y2;  assign d2z = z0 - z2;
   assign rx0 = ox - x0;  assign ry0 = oy - y0;
   assign rx1 = ox - x1;  assign ry1 = oy - y1;
   assign rx2 = ox - x2;  assign ry2 = oy - y2;

   assign e0   = smul(rx0, d0y) - smul(ry0, d0x);
   assign e1   = smul(rx1, d1y) - smul(ry1, d1x);
   assign e2   = smul(rx2, d2y) - smul(ry2, d2x);
   assign det  = smul(d0x, d2y) - smul(d2x, d0y);
   assign dmag = det[W2-1] ? -det : det;
   assign nx   = smul(d1y, z0) + smul(d2y, z1) + smul(d0y, z2);
   assign ny   = -(smul(d1x, z0) + smul(d2x, z1) + smul(d0x, z2));
   assign drop = (det == '0) || ((CULL_EN != 0) && det[W2-1]);

   // restoring divider step; remainder always stays below |det|, so the borrow bit decides
   assign rem_sh  = {rem_q, quo_q[D-1]};
   assign rem_sub = rem_sh - {1'b0, dmag_q};
   assign ge      = ~rem_sub[W2];
   assign rem_d   = ge ? rem_sub[W2-1:0] : rem_sh[W2-1:0];
   assign quo_d   = {quo_q[D-2:0], ge};
   assign dz_res  = sat_q(quo_d, qneg_q);

   assign zc = ({{W{z0[W-1]}}, z0} << FX_FRAC_BITS) + smul(rx0, dzdx_q) + smul(ry0, dzdy_q);

   // sequencer, divider and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rdy_in_q   <= 1'b1;
         vld_out_q  <= 1'b0;
         dneg_q     <= 1'b0;
         qneg_q     <= 1'b0;
         v0_q       <= '0;
         v1_q       <= '0;
         v2_q       <= '0;
         tx_q       <= '0;
         ty_q       <= '0;
         tag_q      <= '0;
         tag_out_q  <= '0;
         e0_q       <= '0;
         e1_q       <= '0;
         e2_q       <= '0;
         ny_q       <= '0;
         dmag_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         dzdx_q     <= '0;
         dzdy_q     <= '0;
         drop_cnt_q <= '0;
         ox_out_q   <= '0;
         oy_out_q   <= '0;
         dzdx_out_q <= '0;
         dzdy_out_q <= '0;
         edge0_q    <= '0;
         edge1_q    <= '0;
         edge2_q    <= '0;
         z_out_q    <= '0;
         dl0_q      <= '0;
         dl1_q      <= '0;
         dl2_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vld_in) begin
                  v0_q     <= v0;
                  v1_q     <= v1;
                  v2_q     <= v2;
                  tx_q     <= tile_x;
                  ty_q     <= tile_y;
                  tag_q    <= tag_in;
                  rdy_in_q <= 1'b0;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               e0_q   <= e0;
               e1_q   <= e1;
               e2_q   <= e2;
               ny_q   <= ny;
               dmag_q <= dmag;
               dneg_q <= det[W2-1];
               rem_q  <= '0;
               quo_q  <= dividend(nx);
               qneg_q <= nx[W2-1] ^ det[W2-1];
               cnt_q  <= CW'(D - 1);
               if (drop) begin
                  rdy_in_q <= 1'b1;
                  state_q  <= IDLE;
                  if (drop_cnt_q != 16'hFFFF)
                     drop_cnt_q <= drop_cnt_q + 16'd1;
               end else begin
                  state_q <= DIV_X;
               end
            end
            DIV_X: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  dzdx_q  <= dz_res;
                  rem_q   <= '0;
                  quo_q   <= dividend(ny_q);
                  qneg_q  <= ny_q[W2-1] ^ dneg_q;
                  cnt_q   <= CW'(D - 1);
                  state_q <= DIV_Y;
               end
            end
            DIV_Y: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  dzdy_q  <= dz_res;
                  state_q <= ZCALC;
               end
            end
            ZCALC: begin
               ox_out_q   <= ox;
               oy_out_q   <= oy;
               edge0_q    <= e0_q;
               edge1_q    <= e1_q;
               edge2_q    <= e2_q;
               dzdx_out_q <= dzdx_q;
               dzdy_out_q <= dzdy_q;
               z_out_q    <= zc;
               dl0_q      <= {d0x, d0y, d0z};
               dl1_q      <= {d1x, d1y, d1z};
               dl2_q      <= {d2x, d2y, d2z};
               tag_out_q  <= tag_q;
               vld_out_q  <= 1'b1;
               state_q    <= OUT;
            end
            OUT: begin
               if (rdy_out) begin
                  vld_out_q <= 1'b0;
                  rdy_in_q  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               vld_out_q <= 1'b0;
               rdy_in_q  <= 1'b1;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign rdy_in       = rdy_in_q;
   assign vld_out      = vld_out_q;
   assign tag_out      = tag_out_q;
   assign out_origin_x = ox_out_q;
   assign out_origin_y = oy_out_q;
   assign out_edge_0   = edge0_q;
   assign out_edge_1   = edge1_q;
   assign out_edge_2   = edge2_q;
   assign out_dzdx     = dzdx_out_q;
   assign out_dzdy     = dzdy_out_q;
   assign out_z        = z_out_q;
   assign out_delta_0  = dl0_q;
   assign out_delta_1  = dl1_q;
   assign out_delta_2  = dl2_q;
   assign drop_count   = drop_cnt_q;

endmodule
